// File: rtl/e203_ifu_prefetch_buf.sv
// IFU prefetch engine: sequential ICB word fetches with a credit limit, PC-tagged response FIFO.
// Define E203_IFU_PFB_BYPASS_EN for same-cycle response bypass when the buffer is empty.
module e203_ifu_prefetch_buf #(
    parameter int unsigned     PC_W   = 32,
    parameter int unsigned     DATA_W = 32,
    parameter int unsigned     DEPTH  = 4,
    parameter int unsigned     OUTS   = 2,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_req,
    input  logic [PC_W-1:0]   flush_pc,
    output logic              flush_ack,
    input  logic              halt_req,
    output logic              halt_ack,
    output logic              icb_cmd_valid,
    input  logic              icb_cmd_ready,
    output logic [PC_W-1:0]   icb_cmd_addr,
    input  logic              icb_rsp_valid,
    output logic              icb_rsp_ready,
    input  logic              icb_rsp_err,
    input  logic [DATA_W-1:0] icb_rsp_rdata,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [DATA_W-1:0] o_instr,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_buserr
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] OUTS_C = CW'(OUTS);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [PC_W-1:0] RST_PC_A = {RST_PC[PC_W-1:2], 2'b00};

    typedef enum logic [1:0] {S_RUN, S_HALT, S_ERR} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [PC_W-1:0]   pc;
        logic              err;
    } ent_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] fpc_q, fpc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outs_q, outs_d, drop_q, drop_d, cnt_q, cnt_d;
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic            halt_ack_q, halt_ack_d;
    ent_t            mem_q [DEPTH];

    logic cmd_hs, rsp_hs, keep, push, pop, empty, credit;
    ent_t rsp_ent, head;
    logic unused_flush_lsb;

    assign unused_flush_lsb = ^flush_pc[1:0];

    assign empty  = (cnt_q == '0);
    assign head   = mem_q[rptr_q];
    // Every issued command is guaranteed a FIFO slot, so responses are never back-pressured.
    assign credit = (outs_q < OUTS_C) && (({1'b0, outs_q} + {1'b0, cnt_q}) < DEPTH_C);

    assign icb_cmd_valid = (state_q == S_RUN) && !flush_req && !halt_req && credit;
    assign icb_cmd_addr  = fpc_q;
    assign icb_rsp_ready = 1'b1;
    assign flush_ack     = flush_req;
    assign halt_ack      = halt_ack_q;

    assign cmd_hs = icb_cmd_valid && icb_cmd_ready;
    assign rsp_hs = icb_rsp_valid;
    assign keep   = rsp_hs && !flush_req && (drop_q == '0);

    always_comb begin
        rsp_ent       = '0;
        rsp_ent.instr = icb_rsp_rdata;
        rsp_ent.pc    = rsp_pc_q;
        rsp_ent.err   = icb_rsp_err;
    end

`ifdef E203_IFU_PFB_BYPASS_EN
    logic byp;
    assign byp      = keep && empty;
    assign o_valid  = !empty || byp;
    assign o_instr  = empty ? icb_rsp_rdata : head.instr;
    assign o_pc     = empty ? rsp_pc_q      : head.pc;
    assign o_buserr = empty ? icb_rsp_err   : head.err;
    assign push     = keep && !(byp && o_ready);
`else
    assign o_valid  = !empty;
    assign o_instr  = head.instr;
    assign o_pc     = head.pc;
    assign o_buserr = head.err;
    assign push     = keep;
`endif
    assign pop = !empty && o_ready;

    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        rsp_pc_d = rsp_pc_q;
        outs_d   = outs_q;
        drop_d   = drop_q;
        cnt_d    = cnt_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;

        if (cmd_hs && !rsp_hs)      outs_d = outs_q + ONE;
        else if (!cmd_hs && rsp_hs) outs_d = outs_q - ONE;

        if (flush_req) begin
            // No command can issue under flush, so outs_d is exactly what is still in flight.
            fpc_d    = {flush_pc[PC_W-1:2], 2'b00};
            rsp_pc_d = {flush_pc[PC_W-1:2], 2'b00};
            cnt_d    = '0;
            wptr_d   = '0;
            rptr_d   = '0;
            drop_d   = outs_d;
            state_d  = halt_req ? S_HALT : S_RUN;
        end else begin
            if (cmd_hs) fpc_d = fpc_q + PC_W'(4);
            if (rsp_hs && (drop_q != '0)) drop_d = drop_q - ONE;
            if (keep) rsp_pc_d = rsp_pc_q + PC_W'(4);
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + ONE;
                2'b01:   cnt_d = cnt_q - ONE;
                default: cnt_d = cnt_q;
            endcase
            case (state_q)
                S_RUN:   if (halt_req)  state_d = S_HALT;
                S_HALT:  if (!halt_req) state_d = S_RUN;
                default: state_d = state_q;
            endcase
            if (keep && icb_rsp_err) state_d = S_ERR;
        end

        halt_ack_d = (state_d == S_HALT) && (outs_d == '0) && (drop_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RUN;
            fpc_q      <= RST_PC_A;
            rsp_pc_q   <= RST_PC_A;
            outs_q     <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            halt_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            rsp_pc_q   <= rsp_pc_d;
            outs_q     <= outs_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            halt_ack_q <= halt_ack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= rsp_ent;
    end

endmodule

// File: doc/e203_ifu_prefetch_buf.md
Name: e203_ifu_prefetch_buf

Overview:
- Parametrised prefetch engine and instruction buffer for the next-generation IFU.
- Sits between the IFU fetch-control stage and the ICB instruction bus.
- Issues sequential word fetches with up to OUTS transactions outstanding and queues responses in a DEPTH-entry FIFO tagged with PC.
- Handles flush (redirect) by discarding in-flight responses, stops on bus error, and supports a halt handshake.

Parameters:
PC_W, 32, PC/address width
DATA_W, 32, instruction word width
DEPTH, 4, FIFO entries; power of 2, >=2
OUTS, 2, max outstanding ICB commands; 1..DEPTH
RST_PC, 32'h0000_0000, fetch PC after reset

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset; asynchronous, active-high
flush_req  in  1  redirect request
flush_pc  in  PC_W  redirect target
flush_ack  out  1  flush accepted
halt_req  in  1  stop issuing fetches
halt_ack  out  1  halted, nothing outstanding
icb_cmd_valid  out  1  fetch command valid
icb_cmd_ready  in  1  bus accepts command
icb_cmd_addr  out  PC_W  fetch address, word aligned
icb_rsp_valid  in  1  response valid
icb_rsp_ready  out  1  response accepted
icb_rsp_err  in  1  response bus error
icb_rsp_rdata  in  DATA_W  response data
o_valid  out  1  buffered instruction available
o_ready  in  1  consumer accepts
o_instr  out  DATA_W  instruction
o_pc  out  PC_W  PC of o_instr
o_buserr  out  1  entry carries bus error

Behaviour:
- Reset: fpc = RST_PC with [1:0] forced to 0; rsp_pc = same; FIFO empty; outstanding = 0; drop_cnt = 0; FSM = RUN.
- Outputs at reset: icb_cmd_valid = 1 (unless halt_req or flush_req); o_valid = 0; halt_ack = 0; icb_rsp_ready = 1.
- FSM RUN:
  - icb_cmd_valid = !flush_req & !halt_req & (outstanding < OUTS) & (outstanding + fifo_count < DEPTH).
  - The credit rule guarantees FIFO space for every response, so icb_rsp_ready is tied 1.
  - icb_cmd_addr = fpc.
  - On cmd handshake: fpc += 4, modulo 2^PC_W (wraps at top of address space).
- Outstanding counter: +1 on cmd handshake, -1 on rsp handshake; unchanged when both occur in the same cycle.
- Response handling:
  - drop_cnt > 0: accepted response is discarded; drop_cnt -= 1.
  - Otherwise: push {rdata, rsp_pc, err} into the FIFO; rsp_pc += 4.
  - If err = 1: FSM -> ERR. Further commands are suppressed; already-outstanding responses are still accepted into the FIFO.
- FSM ERR: icb_cmd_valid = 0 until flush.
- FSM HALT:
  - Entered from RUN when halt_req = 1.
  - halt_ack = (outstanding == 0) & (drop_cnt == 0), registered.
  - Returns to RUN the cycle after halt_req deasserts.
  - The FIFO is still drained by the consumer while halted.
- Flush:
  - flush_ack = flush_req (same cycle), in any state.
  - Next cycle: FIFO cleared; fpc = rsp_pc = {flush_pc[PC_W-1:2], 2'b00}; FSM -> RUN (or HALT if halt_req).
  - drop_cnt = outstanding - (rsp handshake this cycle ? 1 : 0), saturating at 0. No cmd is issued in a flush cycle.
  - A response arriving in the flush cycle is discarded.
  - Flush during HALT or ERR is legal. Back-to-back flushes accumulate correctly.
- FIFO: pop on o_valid & o_ready.
  - Simultaneous push and pop when full is impossible by credit.
  - Simultaneous push and pop when empty: no bypass (see feature).
  - o_valid = !empty; o_instr, o_pc and o_buserr come from the head entry.
- Latency: response accepted in cycle N -> o_valid in cycle N+1.

Optional Feature:
E203_IFU_PFB_BYPASS_EN
- Defined: when the FIFO is empty, drop_cnt = 0, and a response is accepted with no flush, the response drives o_valid/o_instr/o_pc/o_buserr combinationally in the same cycle. If o_ready = 1 the entry is not written into the FIFO; otherwise it is pushed normally.
- Undefined: fixed 1-cycle latency through the FIFO.

Test Plan:
- Reset, RST_PC = 0x100, bus always ready, 1-cycle response: cmd addrs 0x100, 0x104, 0x108...; o_pc in the same order; never more than OUTS = 2 outstanding.
- o_ready = 0 with DEPTH = 4: exactly 4 commands issued, then icb_cmd_valid = 0. Releasing o_ready resumes fetch at 0x110.
- Two commands outstanding, then flush_pc = 0x2002: flush_ack = 1 the same cycle; both late responses dropped; next cmd addr = 0x2000; first o_pc = 0x2000.
- Error response at PC 0x108: entry emerges with o_buserr = 1; no further commands. Flush to 0x300 resumes fetching at 0x300.
- halt_req with one command outstanding: halt_ack = 0 until its response, then 1. Deassert halt_req: fetching resumes at the next sequential PC.
- fpc = 0xFFFF_FFFC (PC_W = 32): the next command addr wraps to 0x0000_0000. With the bypass macro defined, an empty FIFO with o_ready = 1 gives o_valid in the same cycle as icb_rsp_valid.
